// File: rtl/program_loader.sv
// Instruction-memory loader: parses 0xA5-framed byte streams into 16-bit words,
// writes them to imem and holds the core in reset until a frame checksums good.
module program_loader #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 16,
    parameter int NUM_WORDS = 32
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              rx_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [DATA_W-1:0] imem_wdata_o,
    output logic              core_reset_o,
    output logic              load_done_o,
    output logic              load_error_o,
    output logic [5:0]        word_count_o
);

    localparam logic [7:0] SOF = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_HI,
        S_LO,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          hi_q, hi_d;
    logic [7:0]          chk_q, chk_d;
    logic [5:0]          nwords_q, nwords_d;
    logic [5:0]          count_q, count_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                core_reset_q, core_reset_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                accept;
    logic                count_ok;

    // The write-strobe cycle is the only cycle in which bytes are refused.
    assign rx_ready_o = ~we_q;
    assign accept     = rx_valid_i & ~we_q;
    assign count_ok   = (rx_data_i != 8'd0) && (rx_data_i <= 8'(NUM_WORDS));

    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        chk_d        = chk_q;
        nwords_d     = nwords_q;
        count_d      = count_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = 1'b0;
        core_reset_d = core_reset_q;
        done_d       = done_q;
        error_d      = error_q;

        if (accept) begin
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (rx_data_i == SOF) begin
                        state_d      = S_COUNT;
                        core_reset_d = 1'b1;
                        done_d       = 1'b0;
                        error_d      = 1'b0;
                    end
                end
                S_COUNT: begin
                    if (count_ok) begin
                        state_d  = S_HI;
                        nwords_d = rx_data_i[5:0];
                        count_d  = 6'd0;
                        chk_d    = 8'd0;
                        addr_d   = '0;
                    end else begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end
                end
                S_HI: begin
                    hi_d    = rx_data_i;
                    chk_d   = chk_q ^ rx_data_i;
                    state_d = S_LO;
                end
                S_LO: begin
                    chk_d   = chk_q ^ rx_data_i;
                    we_d    = 1'b1;
                    wdata_d = DATA_W'({hi_q, rx_data_i});
                    addr_d  = ADDR_W'(count_q);
                    count_d = count_q + 6'd1;
                    state_d = (count_q + 6'd1 == nwords_q) ? S_CHECK : S_HI;
                end
                S_CHECK: begin
                    if (rx_data_i == chk_q) begin
                        state_d      = S_DONE;
                        done_d       = 1'b1;
                        core_reset_d = 1'b0;
                    end else begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            hi_q         <= 8'd0;
            chk_q        <= 8'd0;
            nwords_q     <= 6'd0;
            count_q      <= 6'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            chk_q        <= chk_d;
            nwords_q     <= nwords_d;
            count_q      <= count_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign core_reset_o = core_reset_q;
    assign load_done_o  = done_q;
    assign load_error_o = error_q;
    assign word_count_o = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed frames plus randomized streams checked
// against a frame-level parser model.
module tb_program_loader;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [4:0]  a;
        logic [15:0] d;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready_o;
    logic        imem_we_o;
    logic [4:0]  imem_addr_o;
    logic [15:0] imem_wdata_o;
    logic        core_reset_o;
    logic        load_done_o;
    logic        load_error_o;
    logic [5:0]  word_count_o;

    int errors = 0;
    int checks = 0;
    int ready_bad = 0;
    wr_t got_wr[$];
    wr_t exp_wr[$];

    logic       mdl_core = 1'b1;
    logic       mdl_done = 1'b0;
    logic       mdl_err  = 1'b0;
    logic [5:0] mdl_wc   = 6'd0;

    always #5 clock = ~clock;

    program_loader #(.ADDR_W(5), .DATA_W(16), .NUM_WORDS(32)) dut (
        .clock_i      (clock),
        .reset_i      (reset),
        .rx_valid_i   (rx_valid),
        .rx_data_i    (rx_data),
        .rx_ready_o   (rx_ready_o),
        .imem_we_o    (imem_we_o),
        .imem_addr_o  (imem_addr_o),
        .imem_wdata_o (imem_wdata_o),
        .core_reset_o (core_reset_o),
        .load_done_o  (load_done_o),
        .load_error_o (load_error_o),
        .word_count_o (word_count_o)
    );

    always @(negedge clock) begin
        if (imem_we_o) got_wr.push_back({imem_addr_o, imem_wdata_o});
        if (imem_we_o === rx_ready_o) ready_bad++;
    end

    // Frame-level reference: scan for 0xA5, parse N, words and checksum.
    task automatic model_stream(input bq_t s);
        int i;
        int n;
        logic [7:0] c;
        i = 0;
        while (i < s.size()) begin
            if (s[i] != 8'hA5) begin
                i++;
                continue;
            end
            mdl_core = 1'b1;
            mdl_done = 1'b0;
            mdl_err  = 1'b0;
            n = int'(s[i+1]);
            if (n == 0 || n > 32) begin
                mdl_err = 1'b1;
                i += 2;
                continue;
            end
            c = 8'd0;
            for (int k = 0; k < n; k++) begin
                exp_wr.push_back({5'(k), s[i+2+2*k], s[i+3+2*k]});
                c ^= s[i+2+2*k] ^ s[i+3+2*k];
            end
            mdl_wc = 6'(n);
            if (s[i+2+2*n] == c) begin
                mdl_done = 1'b1;
                mdl_core = 1'b0;
            end else begin
                mdl_err = 1'b1;
            end
            i += 3 + 2*n;
        end
    endtask

    // Present a byte and hold it until it is accepted; returns 1 time unit after that edge.
    task automatic send_byte(input logic [7:0] b);
        int  n;
        bit  ok;
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        while (1) begin
            ok = rx_ready_o;
            @(posedge clock);
            #1;
            if (ok) break;
            n++;
            if (n > 20) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout byte=%02h never accepted within 20 cycles", b);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_seq(input bq_t s, input int max_gap);
        foreach (s[k]) begin
            send_byte(s[k]);
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
        rx_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        idle(3);
        checks++;
        if ({rx_ready_o, imem_we_o, imem_addr_o, imem_wdata_o, core_reset_o, load_done_o,
             load_error_o, word_count_o} !== {1'b1, 1'b0, 5'd0, 16'd0, 1'b1, 1'b0, 1'b0, 6'd0}) begin
            errors++;
            $display("FAIL reset_values got rdy=%b we=%b addr=%0d wd=%h cr=%b dn=%b er=%b wc=%0d exp 1 0 0 0000 1 0 0 0",
                     rx_ready_o, imem_we_o, imem_addr_o, imem_wdata_o, core_reset_o, load_done_o,
                     load_error_o, word_count_o);
        end
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_good_frame;
        got_wr.delete();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
        checks++;
        if ({imem_we_o, rx_ready_o, imem_addr_o, imem_wdata_o} !== {1'b1, 1'b0, 5'd0, 16'h1234}) begin
            errors++;
            $display("FAIL good_write0 got we=%b rdy=%b addr=%0d data=%h exp we=1 rdy=0 addr=0 data=1234",
                     imem_we_o, rx_ready_o, imem_addr_o, imem_wdata_o);
        end
        send_byte(8'hAB); send_byte(8'hCD);
        checks++;
        if ({imem_we_o, imem_addr_o, imem_wdata_o} !== {1'b1, 5'd1, 16'hABCD}) begin
            errors++;
            $display("FAIL good_write1 got we=%b addr=%0d data=%h exp we=1 addr=1 data=abcd",
                     imem_we_o, imem_addr_o, imem_wdata_o);
        end
        checks++;
        if (core_reset_o !== 1'b1) begin
            errors++;
            $display("FAIL core_held_before_chk got=%b exp=1", core_reset_o);
        end
        send_byte(8'h40);
        rx_valid = 1'b0;
        checks++;
        if ({core_reset_o, load_done_o, load_error_o, word_count_o} !== {1'b0, 1'b1, 1'b0, 6'd2}) begin
            errors++;
            $display("FAIL good_status got cr=%b dn=%b er=%b wc=%0d exp cr=0 dn=1 er=0 wc=2",
                     core_reset_o, load_done_o, load_error_o, word_count_o);
        end
        idle(2);
        checks++;
        if (got_wr.size() != 2) begin
            errors++;
            $display("FAIL good_write_count got=%0d exp=2", got_wr.size());
        end
    endtask

    task automatic test_bad_checksum;
        got_wr.delete();
        send_byte(8'hA5);
        checks++;
        if ({core_reset_o, load_done_o, load_error_o} !== 3'b100) begin
            errors++;
            $display("FAIL rearm_from_done got cr=%b dn=%b er=%b exp 1 0 0", core_reset_o, load_done_o, load_error_o);
        end
        send_seq('{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41}, 0);
        idle(2);
        checks++;
        if ({core_reset_o, load_done_o, load_error_o} !== 3'b101) begin
            errors++;
            $display("FAIL badchk_status got cr=%b dn=%b er=%b exp 1 0 1", core_reset_o, load_done_o, load_error_o);
        end
        checks++;
        if (got_wr.size() != 2 || got_wr[0] !== {5'd0, 16'h1234} || got_wr[1] !== {5'd1, 16'hABCD}) begin
            errors++;
            $display("FAIL badchk_writes got n=%0d exp (0,1234),(1,abcd)", got_wr.size());
        end
    endtask

    task automatic test_bad_count;
        got_wr.delete();
        send_byte(8'hA5);
        checks++;
        if (load_error_o !== 1'b0) begin
            errors++;
            $display("FAIL err_clear_on_a5 got=%b exp=0", load_error_o);
        end
        send_byte(8'h00);
        rx_valid = 1'b0;
        checks++;
        if ({core_reset_o, load_done_o, load_error_o} !== 3'b101) begin
            errors++;
            $display("FAIL count_zero got cr=%b dn=%b er=%b exp 1 0 1", core_reset_o, load_done_o, load_error_o);
        end
        send_seq('{8'hA5, 8'h21}, 0);
        checks++;
        if ({core_reset_o, load_done_o, load_error_o} !== 3'b101) begin
            errors++;
            $display("FAIL count_33 got cr=%b dn=%b er=%b exp 1 0 1", core_reset_o, load_done_o, load_error_o);
        end
        idle(2);
        checks++;
        if (got_wr.size() != 0) begin
            errors++;
            $display("FAIL badcount_writes got=%0d exp=0", got_wr.size());
        end
    endtask

    task automatic test_leading_junk;
        got_wr.delete();
        send_seq('{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h07, 8'h07}, 1);
        idle(2);
        checks++;
        if (got_wr.size() != 1 || got_wr[0] !== {5'd0, 16'h0007}) begin
            errors++;
            $display("FAIL junk_writes got n=%0d exp one write (0,0007)", got_wr.size());
        end
        checks++;
        if ({core_reset_o, load_done_o, load_error_o, word_count_o} !== {3'b010, 6'd1}) begin
            errors++;
            $display("FAIL junk_status got cr=%b dn=%b er=%b wc=%0d exp 0 1 0 1",
                     core_reset_o, load_done_o, load_error_o, word_count_o);
        end
    endtask

    task automatic test_rearm_and_reset;
        got_wr.delete();
        send_byte(8'hA5);
        checks++;
        if ({core_reset_o, load_done_o} !== 2'b10) begin
            errors++;
            $display("FAIL rearm got cr=%b dn=%b exp cr=1 dn=0", core_reset_o, load_done_o);
        end
        send_byte(8'h02);
        send_byte(8'h55);
        rx_valid = 1'b0;
        reset = 1'b1;
        idle(1);
        checks++;
        if ({rx_ready_o, imem_we_o, imem_addr_o, imem_wdata_o, core_reset_o, load_done_o,
             load_error_o, word_count_o} !== {1'b1, 1'b0, 5'd0, 16'd0, 1'b1, 1'b0, 1'b0, 6'd0}) begin
            errors++;
            $display("FAIL midframe_reset got rdy=%b we=%b addr=%0d wd=%h cr=%b dn=%b er=%b wc=%0d",
                     rx_ready_o, imem_we_o, imem_addr_o, imem_wdata_o, core_reset_o, load_done_o,
                     load_error_o, word_count_o);
        end
        reset = 1'b0;
        idle(2);
        checks++;
        if (got_wr.size() != 0) begin
            errors++;
            $display("FAIL midframe_reset_writes got=%0d exp=0", got_wr.size());
        end
    endtask

    task automatic test_back_to_back;
        bq_t s;
        logic [7:0] c;
        got_wr.delete();
        exp_wr.delete();
        s = {};
        c = 8'd0;
        s.push_back(8'hA5);
        s.push_back(8'd32);
        for (int k = 0; k < 64; k++) begin
            s.push_back(8'($urandom));
            c ^= s[s.size()-1];
        end
        s.push_back(c);
        model_stream(s);
        ready_bad = 0;
        send_seq(s, 0);
        idle(2);
        checks++;
        if (ready_bad != 0) begin
            errors++;
            $display("FAIL b2b_ready_pattern got=%0d bad cycles exp=0", ready_bad);
        end
        checks++;
        if (got_wr.size() != exp_wr.size()) begin
            errors++;
            $display("FAIL b2b_write_count got=%0d exp=%0d", got_wr.size(), exp_wr.size());
        end else begin
            foreach (exp_wr[k]) begin
                checks++;
                if (got_wr[k] !== exp_wr[k]) begin
                    errors++;
                    $display("FAIL b2b_write[%0d] got=(%0d,%h) exp=(%0d,%h)", k,
                             got_wr[k].a, got_wr[k].d, exp_wr[k].a, exp_wr[k].d);
                end
            end
        end
        checks++;
        if ({core_reset_o, load_done_o, load_error_o, word_count_o} !== {mdl_core, mdl_done, mdl_err, mdl_wc}) begin
            errors++;
            $display("FAIL b2b_status got cr=%b dn=%b er=%b wc=%0d exp cr=%b dn=%b er=%b wc=%0d",
                     core_reset_o, load_done_o, load_error_o, word_count_o, mdl_core, mdl_done, mdl_err, mdl_wc);
        end
    endtask

    task automatic test_random;
        bq_t s;
        logic [7:0] c;
        logic [7:0] b;
        int n;
        int kind;
        for (int it = 0; it < 8; it++) begin
            got_wr.delete();
            exp_wr.delete();
            s = {};
            repeat ($urandom_range(0, 3)) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h5A;
                s.push_back(b);
            end
            s.push_back(8'hA5);
            kind = $urandom_range(0, 9);
            if (kind == 0) s.push_back(8'd0);
            else if (kind == 1) s.push_back(8'($urandom_range(33, 255)));
            else begin
                n = $urandom_range(1, 32);
                s.push_back(8'(n));
                c = 8'd0;
                for (int k = 0; k < 2*n; k++) begin
                    s.push_back(8'($urandom));
                    c ^= s[s.size()-1];
                end
                if ($urandom_range(0, 3) == 0) c ^= 8'($urandom_range(1, 255));
                s.push_back(c);
            end
            model_stream(s);
            send_seq(s, 2);
            idle(2);
            checks++;
            if (got_wr.size() != exp_wr.size()) begin
                errors++;
                $display("FAIL rnd%0d_write_count got=%0d exp=%0d", it, got_wr.size(), exp_wr.size());
            end else begin
                foreach (exp_wr[k]) begin
                    checks++;
                    if (got_wr[k] !== exp_wr[k]) begin
                        errors++;
                        $display("FAIL rnd%0d_write[%0d] got=(%0d,%h) exp=(%0d,%h)", it, k,
                                 got_wr[k].a, got_wr[k].d, exp_wr[k].a, exp_wr[k].d);
                    end
                end
            end
            checks++;
            if ({core_reset_o, load_done_o, load_error_o, word_count_o} !== {mdl_core, mdl_done, mdl_err, mdl_wc}) begin
                errors++;
                $display("FAIL rnd%0d_status got cr=%b dn=%b er=%b wc=%0d exp cr=%b dn=%b er=%b wc=%0d", it,
                         core_reset_o, load_done_o, load_error_o, word_count_o, mdl_core, mdl_done, mdl_err, mdl_wc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_bad_count();
        test_leading_junk();
        test_rearm_and_reset();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
